// File: rtl/iob_except_reader_pkg.sv
// Shared constants for the IOB exception reader: bundle geometry, the width of
// one slot exception record, the position of its "exception present" bit, the
// reader state encoding and a slot-mask popcount helper.
package iob_except_reader_pkg;

  localparam int IOB_SLOTS     = 10;
  localparam int IOB_BADDR_W   = 6;
  localparam int EXCEPT_WIDTH  = 8;
  localparam int EXC_VALID_BIT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPORT = 2'd2
  } iob_state_e;

  function automatic logic [3:0] slot_count(input logic [IOB_SLOTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < IOB_SLOTS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/iob_except_reader_if.sv
// Request/report bundle between the retire/flush controller and the exception
// reader.
//   req_*  : retire request for one bundle (valid/ready)
//   rep_*  : scan report for that bundle (valid/ready)
// Modports: slave = reader side, master = controller side.
interface iob_except_reader_if
  import iob_except_reader_pkg::*;
#(
  parameter int DATA_WIDTH = EXCEPT_WIDTH,
  parameter int SLOTS      = IOB_SLOTS,
  parameter int BADDR_W    = IOB_BADDR_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic [BADDR_W-1:0]    req_bundle;
  logic [SLOTS-1:0]      req_live;
  logic                  rep_valid;
  logic                  rep_ready;
  logic [BADDR_W-1:0]    rep_bundle;
  logic                  rep_excpt;
  logic [3:0]            rep_slot;
  logic [DATA_WIDTH-1:0] rep_data;
  logic [SLOTS-1:0]      rep_retire_mask;
  logic [3:0]            rep_retire_cnt;

  modport slave (
    input  req_valid, req_bundle, req_live, rep_ready,
    output req_ready, rep_valid, rep_bundle, rep_excpt, rep_slot, rep_data,
           rep_retire_mask, rep_retire_cnt
  );

  modport master (
    output req_valid, req_bundle, req_live, rep_ready,
    input  req_ready, rep_valid, rep_bundle, rep_excpt, rep_slot, rep_data,
           rep_retire_mask, rep_retire_cnt
  );
endinterface

// File: rtl/iob_except_reader_scan.sv
// iob_except_scan: combinational program-order scan of one bundle.
//   recs        in  : SLOTS packed exception records, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   live        in  : slots holding valid, completed instructions
//   excpt       out : some live slot carries an exception
//   slot        out : lowest such slot (0 if none)
//   data        out : its record (0 if none)
//   retire_mask out : live slots below slot, or all live slots if none excepts
//   retire_cnt  out : popcount of retire_mask
module iob_except_scan
  import iob_except_reader_pkg::*;
#(
  parameter int DATA_WIDTH = EXCEPT_WIDTH,
  parameter int SLOTS      = IOB_SLOTS
) (
  input  logic [SLOTS*DATA_WIDTH-1:0] recs,
  input  logic [SLOTS-1:0]            live,
  output logic                        excpt,
  output logic [3:0]                  slot,
  output logic [DATA_WIDTH-1:0]       data,
  output logic [SLOTS-1:0]            retire_mask,
  output logic [3:0]                  retire_cnt
);

  always_comb begin
    excpt = 1'b0;
    slot  = '0;
    data  = '0;
    // Walk downward so the lowest excepting live slot is the last one written.
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (live[k] && recs[k*DATA_WIDTH + EXC_VALID_BIT]) begin
        excpt = 1'b1;
        slot  = 4'(k);
        data  = recs[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    retire_mask = '0;
    for (int k = 0; k < SLOTS; k++) begin
      retire_mask[k] = live[k] && (!excpt || (4'(k) < slot));
    end
    retire_cnt = slot_count(retire_mask);
  end

endmodule

// File: rtl/iob_except_reader.sv
// iob_except_reader: retire-side consumer of the IOB exception RAM.
// Accepts a retire request for one bundle, issues a one-cycle RAM read, scans
// the returned slot records and holds the report until the consumer takes it.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : request/report interface (slave side)
//   read_step  : RAM latches read_addr this cycle
//   read_addr  : bundle index to RAM (follows req_bundle)
//   read_data  : slot records from RAM, valid the cycle after read_step
//   flush      : abort any in-flight scan or report
//
// state  | meaning
// IDLE   | ready for a retire request
// WAIT   | RAM data arriving; scan result captured at the end of this cycle
// REPORT | report presented until rep_ready
module iob_except_reader
  import iob_except_reader_pkg::*;
#(
  parameter int DATA_WIDTH = EXCEPT_WIDTH,
  parameter int SLOTS      = IOB_SLOTS,
  parameter int BADDR_W    = IOB_BADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  iob_except_reader_if.slave          bus,
  output logic                        read_step,
  output logic [BADDR_W-1:0]          read_addr,
  input  logic [SLOTS*DATA_WIDTH-1:0] read_data,
  input  logic                        flush
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_REPORT = REPORT;

  logic [1:0]            state_q, state_d;
  logic [BADDR_W-1:0]    bundle_q, bundle_d;
  logic [SLOTS-1:0]      live_q, live_d;
  logic [BADDR_W-1:0]    rep_bundle_q, rep_bundle_d;
  logic                  rep_excpt_q, rep_excpt_d;
  logic [3:0]            rep_slot_q, rep_slot_d;
  logic [DATA_WIDTH-1:0] rep_data_q, rep_data_d;
  logic [SLOTS-1:0]      rep_mask_q, rep_mask_d;
  logic [3:0]            rep_cnt_q, rep_cnt_d;

  logic                  req_ready;
  logic                  accept;
  logic                  scan_excpt;
  logic [3:0]            scan_slot;
  logic [DATA_WIDTH-1:0] scan_data;
  logic [SLOTS-1:0]      scan_mask;
  logic [3:0]            scan_cnt;

  // rst gates the handshake so no read is issued while the block is held in reset.
  assign req_ready = (state_q == ST_IDLE) && !flush && rst;
  assign accept    = bus.req_valid && req_ready;
  assign read_step = accept;
  assign read_addr = bus.req_bundle;

  assign bus.req_ready       = req_ready;
  assign bus.rep_valid       = (state_q == ST_REPORT);
  assign bus.rep_bundle      = rep_bundle_q;
  assign bus.rep_excpt       = rep_excpt_q;
  assign bus.rep_slot        = rep_slot_q;
  assign bus.rep_data        = rep_data_q;
  assign bus.rep_retire_mask = rep_mask_q;
  assign bus.rep_retire_cnt  = rep_cnt_q;

  iob_except_scan #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOTS      (SLOTS)
  ) u_scan (
    .recs        (read_data),
    .live        (live_q),
    .excpt       (scan_excpt),
    .slot        (scan_slot),
    .data        (scan_data),
    .retire_mask (scan_mask),
    .retire_cnt  (scan_cnt)
  );

  always_comb begin
    state_d      = state_q;
    bundle_d     = bundle_q;
    live_d       = live_q;
    rep_bundle_d = rep_bundle_q;
    rep_excpt_d  = rep_excpt_q;
    rep_slot_d   = rep_slot_q;
    rep_data_d   = rep_data_q;
    rep_mask_d   = rep_mask_q;
    rep_cnt_d    = rep_cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bundle_d = bus.req_bundle;
            live_d   = bus.req_live;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          rep_bundle_d = bundle_q;
          rep_excpt_d  = scan_excpt;
          rep_slot_d   = scan_slot;
          rep_data_d   = scan_data;
          rep_mask_d   = scan_mask;
          rep_cnt_d    = scan_cnt;
          state_d      = ST_REPORT;
        end
        ST_REPORT: begin
          if (bus.rep_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bundle_q     <= '0;
      live_q       <= '0;
      rep_bundle_q <= '0;
      rep_excpt_q  <= 1'b0;
      rep_slot_q   <= '0;
      rep_data_q   <= '0;
      rep_mask_q   <= '0;
      rep_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bundle_q     <= bundle_d;
      live_q       <= live_d;
      rep_bundle_q <= rep_bundle_d;
      rep_excpt_q  <= rep_excpt_d;
      rep_slot_q   <= rep_slot_d;
      rep_data_q   <= rep_data_d;
      rep_mask_q   <= rep_mask_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

endmodule
